// File: rtl/vm_coin_timer_return_pkg.sv
// Shared definitions for the coin balance / inactivity timer / change-return block.
// Holds the FSM state encoding, default geometry (coin count, balance width,
// coin values, timer reload) and fixed output widths.
package vm_coin_timer_return_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_e;

  localparam int unsigned DEF_NUM_COINS   = 3;
  localparam int unsigned DEF_BAL_W       = 16;
  localparam int unsigned DEF_WAIT_CYCLES = 100;
  localparam int unsigned TIMER_W         = 32;
  localparam int unsigned STATS_W         = 16;

  localparam logic [DEF_NUM_COINS*DEF_BAL_W-1:0] DEF_COIN_VALUES =
    {16'd1000, 16'd500, 16'd100};

endpackage

// File: rtl/vm_coin_timer_return_if.sv
// Coin acceptor / dispense-controller bus for vm_coin_timer_return.
// master: coin acceptor + dispense logic side (drives i_*, observes o_*).
// slave : the coin/timer/return block.
// Signals: i_input_coin, i_spend_valid, i_spend_amt, i_return_req,
//          o_balance, o_wait_time, o_return_coin, o_returning,
//          o_spend_ack, o_spend_err, o_coin_reject,
//          o_returned_cnt (only when VM_RETURN_STATS_EN is defined).
interface vm_coin_timer_return_if
  import vm_coin_timer_return_pkg::*;
#(
  parameter int unsigned NUM_COINS = DEF_NUM_COINS,
  parameter int unsigned BAL_W     = DEF_BAL_W
);

  logic [NUM_COINS-1:0] i_input_coin;
  logic                 i_spend_valid;
  logic [BAL_W-1:0]     i_spend_amt;
  logic                 i_return_req;
  logic [BAL_W-1:0]     o_balance;
  logic [TIMER_W-1:0]   o_wait_time;
  logic [NUM_COINS-1:0] o_return_coin;
  logic                 o_returning;
  logic                 o_spend_ack;
  logic                 o_spend_err;
  logic                 o_coin_reject;
`ifdef VM_RETURN_STATS_EN
  logic [NUM_COINS*STATS_W-1:0] o_returned_cnt;
`endif

  modport master (
    output i_input_coin, i_spend_valid, i_spend_amt, i_return_req,
    input  o_balance, o_wait_time, o_return_coin, o_returning,
           o_spend_ack, o_spend_err, o_coin_reject
`ifdef VM_RETURN_STATS_EN
    , input o_returned_cnt
`endif
  );

  modport slave (
    input  i_input_coin, i_spend_valid, i_spend_amt, i_return_req,
    output o_balance, o_wait_time, o_return_coin, o_returning,
           o_spend_ack, o_spend_err, o_coin_reject
`ifdef VM_RETURN_STATS_EN
    , output o_returned_cnt
`endif
  );

endinterface

// File: rtl/vm_coin_timer_return_wait_timer.sv
// Loadable saturating down-counter used as the inactivity timer.
// Ports: clk, reset_n (sync, active-low), load (reload to LOAD_VAL),
//        dec (count down, stops at 0), clear (force 0, highest priority),
//        count (registered value), zero_c (combinational count==0 flag).
module vm_coin_timer_return_wait_timer
  import vm_coin_timer_return_pkg::*;
#(
  parameter int unsigned LOAD_VAL = DEF_WAIT_CYCLES
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               dec,
  input  logic               clear,
  output logic [TIMER_W-1:0] count,
  output logic               zero_c
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= TIMER_W'(LOAD_VAL);
    end else if (dec && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/vm_coin_timer_return.sv
// Coin balance, inactivity timer and greedy change return.
// Accumulates inserted coins, deducts accepted spends, reloads the timer on
// every accepted user action and, on timeout or return request, pays the
// balance out one coin per cycle, largest denomination first.
// Ports: clk, reset_n (sync, active-low), bus (vm_coin_timer_return_if.slave).
// Optional: define VM_RETURN_STATS_EN to add per-denomination payout counters
// on bus.o_returned_cnt.
module vm_coin_timer_return
  import vm_coin_timer_return_pkg::*;
#(
  parameter int unsigned                NUM_COINS   = DEF_NUM_COINS,
  parameter int unsigned                BAL_W       = DEF_BAL_W,
  parameter logic [NUM_COINS*BAL_W-1:0] COIN_VALUES = DEF_COIN_VALUES,
  parameter int unsigned                WAIT_CYCLES = DEF_WAIT_CYCLES
)(
  input logic                  clk,
  input logic                  reset_n,
  vm_coin_timer_return_if.slave bus
);

  localparam int unsigned SUM_W = BAL_W + 2;
  localparam int unsigned TOT_W = BAL_W + 3;

  function automatic logic [BAL_W-1:0] coin_value(input int unsigned k);
    return COIN_VALUES[k*BAL_W +: BAL_W];
  endfunction

  state_e               state_q, state_d;
  logic [BAL_W-1:0]     balance_q, balance_d;
  logic [NUM_COINS-1:0] coin_q, coin_d;
  logic                 returning_q, returning_d;
  logic                 spend_ack_q, spend_ack_d;
  logic                 spend_err_q, spend_err_d;
  logic                 coin_reject_q, coin_reject_d;

  logic [SUM_W-1:0]     coin_sum;
  logic [TOT_W-1:0]     total;
  logic                 any_coin, overflow, coin_ok, spend_ok, reload;
  logic [BAL_W-1:0]     avail, bal_after, pick_val;
  logic [NUM_COINS-1:0] pick_hot;
  logic                 pay;

  logic                 t_load, t_dec, t_clear, t_zero;
  logic [TIMER_W-1:0]   t_count;

  // Credit/spend arithmetic and greedy coin choice for this cycle
  always_comb begin
    coin_sum = '0;
    for (int unsigned k = 0; k < NUM_COINS; k++) begin
      if (bus.i_input_coin[k]) coin_sum = coin_sum + SUM_W'(coin_value(k));
    end
    total     = TOT_W'(balance_q) + TOT_W'(coin_sum);
    any_coin  = |bus.i_input_coin;
    overflow  = |total[TOT_W-1:BAL_W];
    coin_ok   = any_coin && !overflow;
    avail     = coin_ok ? total[BAL_W-1:0] : balance_q;
    spend_ok  = bus.i_spend_valid && (state_q != ST_RETURN) &&
                (bus.i_spend_amt <= avail);
    bal_after = spend_ok ? (avail - bus.i_spend_amt) : avail;
    reload    = coin_ok || spend_ok;
    // ascending scan: the last fitting coin is the largest one
    pick_hot  = '0;
    pick_val  = '0;
    for (int unsigned k = 0; k < NUM_COINS; k++) begin
      if (coin_value(k) <= bal_after) begin
        pick_hot    = '0;
        pick_hot[k] = 1'b1;
        pick_val    = coin_value(k);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    balance_d     = bal_after;
    coin_d        = '0;
    returning_d   = 1'b0;
    spend_ack_d   = spend_ok;
    spend_err_d   = bus.i_spend_valid && !spend_ok;
    coin_reject_d = any_coin && overflow;
    t_load        = 1'b0;
    t_dec         = 1'b0;
    t_clear       = 1'b0;
    pay           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (coin_ok) begin
          state_d = ST_ACTIVE;
          t_load  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (bus.i_return_req ||
            (!reload && (t_zero || (t_count == TIMER_W'(1))))) begin
          t_clear = 1'b1;
          pay     = 1'b1;
        end else if (reload) begin
          t_load = 1'b1;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_RETURN: begin
        t_clear = 1'b1;
        pay     = 1'b1;
      end
      default: begin
        state_d   = ST_IDLE;
        balance_d = '0;
        t_clear   = 1'b1;
      end
    endcase

    // First coin leaves on the exit edge so o_returning spans exactly the payout
    if (pay) begin
      if (pick_hot != '0) begin
        coin_d      = pick_hot;
        balance_d   = bal_after - pick_val;
        returning_d = 1'b1;
        state_d     = (balance_d != '0) ? ST_RETURN : ST_IDLE;
      end else begin
        balance_d = '0;
        state_d   = ST_IDLE;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      balance_q     <= '0;
      coin_q        <= '0;
      returning_q   <= 1'b0;
      spend_ack_q   <= 1'b0;
      spend_err_q   <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      balance_q     <= balance_d;
      coin_q        <= coin_d;
      returning_q   <= returning_d;
      spend_ack_q   <= spend_ack_d;
      spend_err_q   <= spend_err_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  vm_coin_timer_return_wait_timer #(
    .LOAD_VAL (WAIT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (t_load),
    .dec     (t_dec),
    .clear   (t_clear),
    .count   (t_count),
    .zero_c  (t_zero)
  );

`ifdef VM_RETURN_STATS_EN
  logic [NUM_COINS*STATS_W-1:0] cnt_q;

  // Saturating per-denomination payout counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_COINS; k++) begin
        if (coin_d[k] && (cnt_q[k*STATS_W +: STATS_W] != {STATS_W{1'b1}})) begin
          cnt_q[k*STATS_W +: STATS_W] <= cnt_q[k*STATS_W +: STATS_W] + STATS_W'(1);
        end
      end
    end
  end

  assign bus.o_returned_cnt = cnt_q;
`endif

  assign bus.o_balance     = balance_q;
  assign bus.o_wait_time   = t_count;
  assign bus.o_return_coin = coin_q;
  assign bus.o_returning   = returning_q;
  assign bus.o_spend_ack   = spend_ack_q;
  assign bus.o_spend_err   = spend_err_q;
  assign bus.o_coin_reject = coin_reject_q;

endmodule

// File: doc/vm_coin_timer_return.md
Name: vm_coin_timer_return

Overview:
Parametrised coin-balance, inactivity-timer and change-return block for the vending machine datapath. It accumulates inserted coin values, accepts spend requests from the dispense logic, and runs a countdown timer that reloads on every user action. When the timer expires or a return is requested, it pays out the remaining balance greedily, one coin per cycle, largest denomination first. It sits between the coin acceptor inputs and the item-dispense controller.

Parameters:
NUM_COINS, 3, number of coin denominations (>=1)
BAL_W, 16, balance/value width in bits
COIN_VALUES, {16'd1000,16'd500,16'd100}, packed NUM_COINS*BAL_W vector; slice k = value of coin k; strictly ascending with k
WAIT_CYCLES, 100, timer reload value (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
i_input_coin  in  NUM_COINS  one-cycle pulse per inserted coin; multiple bits = multiple coins this cycle
i_spend_valid  in  1  dispense logic requests deduction
i_spend_amt  in  BAL_W  amount to deduct
i_return_req  in  1  user pressed return; pulse
o_balance  out  BAL_W  current credited balance
o_wait_time  out  32  remaining cycles before auto-return
o_return_coin  out  NUM_COINS  one-hot coin ejected this cycle, 0 otherwise
o_returning  out  1  high while in RETURN state
o_spend_ack  out  1  one-cycle pulse, spend accepted
o_spend_err  out  1  one-cycle pulse, spend rejected
o_coin_reject  out  1  one-cycle pulse, coin(s) rejected on overflow

Behaviour:
- Reset (reset_n=0 at posedge clk): state IDLE, o_balance=0, o_wait_time=0, o_return_coin=0, o_returning=0, all pulse outputs 0. Reset mid-RETURN aborts payout; remaining balance is discarded.
- All outputs registered; every response appears in the cycle after the causing input.
- coin_sum = sum of COIN_VALUES[k] for every set bit of i_input_coin, computed at BAL_W+2 bits.
- Overflow: if balance + coin_sum > 2^BAL_W-1, all coins of that cycle are rejected: o_coin_reject=1, balance unchanged, timer not reloaded.
- Spend: accepted iff i_spend_valid and i_spend_amt <= balance + accepted coin_sum and state != RETURN. Accepted: balance decreases by i_spend_amt, o_spend_ack=1. Otherwise o_spend_err=1, balance unaffected by the spend.
- Same-cycle coin and spend: next balance = balance + coin_sum - i_spend_amt.
- States:
- IDLE: balance=0, timer=0. Accepted coin -> ACTIVE, timer=WAIT_CYCLES.
- ACTIVE: any accepted coin or accepted spend reloads timer to WAIT_CYCLES; otherwise timer decrements by 1. The transition is taken when (timer==1 and no reload) or when i_return_req=1. If balance>0 -> RETURN; if balance=0 -> IDLE. timer=0 on exit.
- RETURN: o_returning=1. Each cycle, select the highest k with COIN_VALUES[k] <= balance; drive o_return_coin one-hot at k and subtract its value. When balance reaches 0 -> IDLE. If no coin fits a nonzero residue, discard the residue and go to IDLE. Coins inserted during RETURN are credited and included in the payout. Timer is held at 0. i_return_req is ignored.
- Timer never wraps below 0; o_wait_time saturates at 0.
- i_return_req in IDLE: no effect.

Optional Feature:
Macro VM_RETURN_STATS_EN.
- Defined: adds output o_returned_cnt (NUM_COINS*16 bits), one 16-bit saturating counter per denomination, incremented on each o_return_coin bit. Reset to 0.
- Undefined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- Shared header vm_pkg (`include file): state encodings (ST_IDLE, ST_ACTIVE, ST_RETURN), default coin values and widths, and the greedy-select function (value -> one-hot coin).
- One sub-module: vm_wait_timer, a loadable saturating down-counter with load/dec/clear inputs and a zero flag.

Test Plan:
- Reset then insert coin 1 (500) -> next cycle balance=500, wait_time=100, then decrements to 0 over 100 cycles. Then RETURN: o_return_coin=3'b010 for one cycle, balance=0, IDLE.
- Insert 1000+100 in the same cycle, then i_return_req -> return sequence 3'b100 then 3'b001, o_returning high for exactly 2 cycles.
- Balance 600, i_spend_amt=700 -> o_spend_err=1, balance stays 600. Then spend 400 -> o_spend_ack=1, balance=200, wait_time reloads to 100.
- Coin inserted at wait_time=1 -> timer reloads to 100, no RETURN entered.
- BAL_W=10, balance 1000, insert 100 -> o_coin_reject=1, balance stays 1000. Reset asserted mid-RETURN -> all outputs 0 the next cycle.
- With VM_RETURN_STATS_EN: return 1500 -> o_returned_cnt for coin 2 = 1 and for coin 1 = 1.
